// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetcher with branch/jump next-PC selection
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc_out,
    output logic [31:0] link_pc,
    input  logic        branch_z,
    input  logic        branch_nz,
    input  logic        jmp,
    input  logic        jmp_r,
    input  logic        zero,
    input  logic [31:0] reg_target,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t      state;
    logic [31:0] pc, raw_pc, next_pc;
    logic        consume, taken;
    assign consume   = inst_valid & inst_ready;
    assign taken     = jmp | jmp_r | (branch_z & zero) | (branch_nz & ~zero);
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign link_pc   = pc + 32'd4;
    // next-PC priority: register jump, then relative jump, then taken branch, else fall through
    always_comb begin
        raw_pc  = jmp_r ? reg_target
                : jmp   ? link_pc + {{6{inst[25]}}, inst[25:0]}
                : taken ? link_pc + {{16{inst[15]}}, inst[15:0]}
                :         link_pc;
        next_pc = {raw_pc[31:2], 2'b00};
    end
    // fetch FSM: request until ack, hold the word until the decoder consumes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            inst         <= 32'd0;
            inst_valid   <= 1'b0;
            imem_req     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    inst       <= imem_rdata;
                    inst_valid <= 1'b1;
                    imem_req   <= 1'b0;
                    state      <= HOLD;
                end
                HOLD: if (consume) begin
                    inst_valid <= 1'b0;
                    pc         <= next_pc;
                    imem_req   <= 1'b1;
                    state      <= FETCH;
                    if (jmp_r && reg_target[1:0] != 2'b00) misalign_err <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed fetch, stall, branch, jump, wrap and reset checks
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_ready = 1'b0;
    logic        branch_z = 1'b0, branch_nz = 1'b0, jmp = 1'b0, jmp_r = 1'b0, zero = 1'b0;
    logic [31:0] reg_target = 32'd0;
    logic        imem_req, inst_valid, misalign_err;
    logic [31:0] imem_addr, inst, pc_out, link_pc;
    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_inst, w_pc, w_link;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ifetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .pc_out(pc_out), .link_pc(link_pc), .branch_z(branch_z),
        .branch_nz(branch_nz), .jmp(jmp), .jmp_r(jmp_r), .zero(zero),
        .reg_target(reg_target), .misalign_err(misalign_err)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(w_inst), .inst_valid(w_valid),
        .inst_ready(inst_ready), .pc_out(w_pc), .link_pc(w_link), .branch_z(branch_z),
        .branch_nz(branch_nz), .jmp(jmp), .jmp_r(jmp_r), .zero(zero),
        .reg_target(reg_target), .misalign_err(w_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // zero-wait fetch of one word at the expected address
    task automatic fetch_word(input logic [31:0] data, input logic [31:0] addr);
        check("req_before_ack", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        check("valid_after_ack", {31'd0, inst_valid}, 32'd1);
        check("inst_latched", inst, data);
        check("pc_out", pc_out, addr);
        check("link_pc", link_pc, addr + 32'd4);
        check("req_in_hold", {31'd0, imem_req}, 32'd0);
    endtask

    // consume with control vector {jmp_r,jmp,branch_nz,branch_z,zero}
    task automatic consume(input logic [4:0] ctl, input logic [31:0] tgt, input logic [31:0] exp_next);
        {jmp_r, jmp, branch_nz, branch_z, zero} = ctl;
        reg_target = tgt;
        inst_ready = 1'b1;
        tick();
        {jmp_r, jmp, branch_nz, branch_z, zero} = 5'd0;
        inst_ready = 1'b0;
        check("valid_cleared", {31'd0, inst_valid}, 32'd0);
        check("req_after_consume", {31'd0, imem_req}, 32'd1);
        check("next_addr", imem_addr, exp_next);
    endtask

    initial begin
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_link", link_pc, 32'd4);
        check("rst_err", {31'd0, misalign_err}, 32'd0);
        check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_rst_link", w_link, 32'd0);
        rst_n = 1'b1;
        #1 check("req_low_at_release", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        // sequential zero-wait fetch; wrap instance runs in lockstep
        fetch_word(32'h0000_0013, 32'h0);
        consume(5'b00000, 32'd0, 32'h4);
        check("wrap_next_addr", w_addr, 32'h0);
        check("wrap_req", {31'd0, w_req}, 32'd1);
        fetch_word(32'h0000_0033, 32'h4);
        consume(5'b00000, 32'd0, 32'h8);
        // memory wait states: request and address must hold
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h8);
            check("wait_valid", {31'd0, inst_valid}, 32'd0);
        end
        fetch_word(32'hA5A5_0001, 32'h8);
        // decoder stalls; stray acks and control must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        jmp        = 1'b1;
        jmp_r      = 1'b1;
        reg_target = 32'h0000_0777;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst", inst, 32'hA5A5_0001);
            check("stall_pc", pc_out, 32'h8);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_err", {31'd0, misalign_err}, 32'd0);
        end
        imem_ack = 1'b0;
        {jmp, jmp_r} = 2'b00;
        consume(5'b00000, 32'd0, 32'hC);
        // jmp 0x10 + 0xF0 -> 0x100
        fetch_word(32'h0000_00F0, 32'hC);
        consume(5'b01000, 32'd0, 32'h100);
        // taken beq: 0x104 - 8 -> 0xFC
        fetch_word(32'h1234_FFF8, 32'h100);
        consume(5'b00011, 32'd0, 32'hFC);
        fetch_word(32'h0, 32'hFC);
        consume(5'b00000, 32'd0, 32'h100);
        // not-taken beq -> 0x104
        fetch_word(32'h1234_FFF8, 32'h100);
        consume(5'b00010, 32'd0, 32'h104);
        // jmp -8 from 0x108 -> 0x100
        fetch_word(32'h03FF_FFF8, 32'h104);
        consume(5'b01000, 32'd0, 32'h100);
        // taken bnz -> 0xFC
        fetch_word(32'h1234_FFF8, 32'h100);
        consume(5'b00100, 32'd0, 32'hFC);
        // jmp 0x100 + 0x100 -> 0x200
        fetch_word(32'h0000_0100, 32'hFC);
        consume(5'b01000, 32'd0, 32'h200);
        // jmp 0x204 + 0x10 -> 0x214
        fetch_word(32'h0000_0010, 32'h200);
        consume(5'b01000, 32'd0, 32'h214);
        check("err_before_jr", {31'd0, misalign_err}, 32'd0);
        // jmp_r wins over everything; misaligned target is cleared and flagged
        fetch_word(32'h0000_0010, 32'h214);
        consume(5'b11011, 32'h0000_1236, 32'h1234);
        check("err_set", {31'd0, misalign_err}, 32'd1);
        fetch_word(32'h0, 32'h1234);
        consume(5'b10000, 32'h0000_0040, 32'h40);
        check("err_sticky", {31'd0, misalign_err}, 32'd1);
        // reset mid-fetch with an ack present during and after reset
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        rst_n      = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc", pc_out, 32'h0);
        check("mid_rst_err", {31'd0, misalign_err}, 32'd0);
        check("mid_rst_inst", inst, 32'd0);
        tick();
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("post_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("post_rst_inst", inst, 32'd0);
        fetch_word(32'h0000_0093, 32'h0);
        consume(5'b00000, 32'd0, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the fetch address after reset (word aligned).
REQ-002 The block SHALL have one clock. Reset SHALL be asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  instruction memory read request.
REQ-006 imem_addr  out  32  instruction memory word address; bits [1:0] always 0.
REQ-007 imem_ack  in  1  memory returns read data this cycle.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 inst  out  32  instruction presented to the decoder.
REQ-010 inst_valid  out  1  inst is valid.
REQ-011 inst_ready  in  1  downstream consumes inst this cycle.
REQ-012 pc_out  out  32  address of inst.
REQ-013 link_pc  out  32  pc_out+4, the link value for JAL/JALR.
REQ-014 branch_z, branch_nz, jmp, jmp_r  in  1 each  decoded control for inst, sampled only on consume.
REQ-015 zero  in  1  branch operand equals 0.
REQ-016 reg_target  in  32  register value used as the JR/JALR target.
REQ-017 misalign_err  out  1  sticky flag: a JR/JALR target had nonzero bits [1:0].

Function
REQ-018 FSM states SHALL be IDLE, FETCH and HOLD. Reset state SHALL be IDLE.
REQ-019 IDLE SHALL move to FETCH unconditionally on the next clock.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; both SHALL stay stable until imem_ack.
REQ-021 imem_ack in FETCH SHALL latch imem_rdata into inst, set inst_valid=1 and move to HOLD on the same edge; an ack in the first FETCH cycle SHALL be legal.
REQ-022 imem_ack outside FETCH SHALL be ignored.
REQ-023 In HOLD, imem_req SHALL be 0, and inst and pc_out SHALL stay constant until inst_ready=1.
REQ-024 Consume is inst_valid & inst_ready. On consume the FSM SHALL clear inst_valid, load pc with next_pc and move to FETCH.
REQ-025 taken SHALL equal jmp | jmp_r | (branch_z & zero) | (branch_nz & ~zero).
REQ-026 next_pc SHALL be selected in this priority order:
  - jmp_r: {reg_target[31:2],2'b00}
  - jmp: link_pc + sign-extended inst[25:0]
  - taken branch: link_pc + sign-extended inst[15:0]
  - otherwise: link_pc
REQ-027 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-028 The computed jump and branch targets SHALL have bits [1:0] forced to 0.
REQ-029 A consume with jmp_r=1 and reg_target[1:0]!=0 SHALL set misalign_err. It SHALL stay set until reset; the target is still taken with low bits cleared.
REQ-030 Control inputs SHALL be ignored in cycles without a consume.
REQ-031 Fetch latency SHALL be one cycle from consume to imem_req; a zero-wait memory therefore yields one instruction every 2 cycles.

Reset
REQ-032 While rst_n=0, the outputs SHALL be:
  - pc=RESET_PC, pc_out=RESET_PC, link_pc=RESET_PC+4
  - inst=0, inst_valid=0, imem_req=0, misalign_err=0
  - FSM in IDLE
REQ-033 Reset asserted mid-fetch SHALL abandon the request immediately; an ack arriving during or right after reset SHALL be discarded.
REQ-034 The first imem_req SHALL assert in the second cycle after rst_n rises, with imem_addr=RESET_PC.

Verification
REQ-035 Sequential fetch with a zero-wait memory and inst_ready=1 → imem_addr 0x0, 0x4, 0x8; inst_valid pulses every 2nd cycle; link_pc=pc_out+4.
REQ-036 Memory holds ack for 3 cycles with inst_ready=0 for 5 cycles → addr and req stable until ack; inst and pc_out stable until consume.
REQ-037 Branches:
  - pc_out=0x100, branch_z=1, zero=1, inst[15:0]=0xFFF8 → next imem_addr 0xFC.
  - Same stimulus with zero=0 → 0x104.
  - branch_nz=1, zero=0 → 0xFC.
REQ-038 Jumps:
  - pc_out=0x200, jmp=1, inst[25:0]=0x0000010 → 0x214.
  - jmp_r=1, reg_target=0x1236 → 0x1234 and misalign_err=1.
REQ-039 Wrap: RESET_PC=0xFFFF_FFFC, sequential consume → next imem_addr 0x0.
REQ-040 rst_n pulsed low while imem_req=1 and pc=0x40; ack arrives during reset → outputs at reset values, the ack is discarded, and the refetch starts at RESET_PC.
